// File: rtl/ldl_rr_req_agent_if.sv
`default_nettype none
// ============================================================================
// Module  : ldl_rr_req_agent_if
// Brief   : Push, arbiter and downstream signals of the round-robin requester.
// Revision: 1.0
// ============================================================================
interface ldl_rr_req_agent_if #(
  parameter int BIN_WIDTH = 3,
  parameter int COS_WIDTH = 2
);
  localparam int REQ_WIDTH = 1 << BIN_WIDTH;

  logic [REQ_WIDTH-1:0]           push;
  logic [REQ_WIDTH*COS_WIDTH-1:0] push_cos;
  logic [REQ_WIDTH-1:0]           push_ready;
  logic [REQ_WIDTH-1:0]           req;
  logic [REQ_WIDTH*COS_WIDTH-1:0] cos;
  logic                           arb_valid;
  logic [BIN_WIDTH-1:0]           arb_bin;
  logic [REQ_WIDTH-1:0]           arb_hot;
  logic                           arb_ready;
  logic                           out_valid;
  logic [BIN_WIDTH-1:0]           out_bin;
  logic [COS_WIDTH-1:0]           out_cos;
  logic                           out_ready;
  logic                           err;

  modport master (
    input  push, push_cos, arb_valid, arb_bin, arb_hot, out_ready,
    output push_ready, req, cos, arb_ready, out_valid, out_bin, out_cos, err
  );

  modport slave (
    output push, push_cos, arb_valid, arb_bin, arb_hot, out_ready,
    input  push_ready, req, cos, arb_ready, out_valid, out_bin, out_cos, err
  );
endinterface
`default_nettype wire

// File: rtl/ldl_rr_req_agent.sv
`default_nettype none
// ============================================================================
// Module  : ldl_rr_req_agent
// Brief   : Per-source COS queues feeding a round-robin arbiter; forwards grants.
// Revision: 1.0
// ============================================================================
module ldl_rr_req_agent #(
  parameter int BIN_WIDTH   = 3,
  parameter int COS_WIDTH   = 2,
  parameter int QDEPTH_LOG2 = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  ldl_rr_req_agent_if.master    bus
);
  localparam int REQ_WIDTH = 1 << BIN_WIDTH;
  localparam int c_qdepth  = 1 << QDEPTH_LOG2;
  localparam logic [QDEPTH_LOG2:0]  c_cnt_full = (QDEPTH_LOG2+1)'(c_qdepth);
  localparam logic [QDEPTH_LOG2:0]  c_cnt_one  = (QDEPTH_LOG2+1)'(1);
  localparam logic [REQ_WIDTH-1:0]  c_req_one  = REQ_WIDTH'(1);

  logic [REQ_WIDTH-1:0] w_push_ready;
  logic [REQ_WIDTH-1:0] w_req;
  logic [REQ_WIDTH-1:0] w_ovf;
  logic [COS_WIDTH-1:0] w_head [REQ_WIDTH];
  logic                 w_arb_ready;
  logic                 w_accept;
  logic                 w_onehot;
  logic                 w_legal;
  logic                 w_grant_ok;

  logic                 r_out_valid;
  logic [BIN_WIDTH-1:0] r_out_bin;
  logic [COS_WIDTH-1:0] r_out_cos;
  logic                 r_err;

  assign w_arb_ready = !r_out_valid || bus.out_ready;
  assign w_accept    = bus.arb_valid && w_arb_ready;
  assign w_onehot    = (bus.arb_hot != '0) && ((bus.arb_hot & (bus.arb_hot - c_req_one)) == '0);
  // Grant on an empty source is the underflow case and is rejected here.
  assign w_legal     = w_onehot && (bus.arb_hot == (c_req_one << bus.arb_bin)) && w_req[bus.arb_bin];
  assign w_grant_ok  = w_accept && w_legal;

  for (genvar gi = 0; gi < REQ_WIDTH; gi++) begin : g_src
    logic [COS_WIDTH-1:0]   r_mem [c_qdepth];
    logic [QDEPTH_LOG2-1:0] r_wp;
    logic [QDEPTH_LOG2-1:0] r_rp;
    logic [QDEPTH_LOG2-1:0] w_rp_nxt;
    logic [QDEPTH_LOG2:0]   r_cnt;
    logic [QDEPTH_LOG2:0]   w_cnt_nxt;
    logic                   r_req;
    logic [COS_WIDTH-1:0]   r_head;
    logic [COS_WIDTH-1:0]   w_head_nxt;
    logic [COS_WIDTH-1:0]   w_pcos;
    logic                   w_enq;
    logic                   w_pop;

    assign w_pcos           = bus.push_cos[gi*COS_WIDTH +: COS_WIDTH];
    assign w_push_ready[gi] = (r_cnt != c_cnt_full);
    assign w_enq            = bus.push[gi] && w_push_ready[gi];
    assign w_ovf[gi]        = bus.push[gi] && !w_push_ready[gi];
    assign w_pop            = w_grant_ok && (bus.arb_bin == BIN_WIDTH'(gi));
    assign w_rp_nxt         = r_rp + 1'b1;

    always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_enq && !w_pop)
        w_cnt_nxt = r_cnt + 1'b1;
      else if (!w_enq && w_pop)
        w_cnt_nxt = r_cnt - 1'b1;
    end

    // With one entry left, a same-cycle push is not yet in memory, so bypass it.
    always_comb begin
      w_head_nxt = r_head;
      if (w_pop) begin
        if (r_cnt == c_cnt_one)
          w_head_nxt = w_enq ? w_pcos : '0;
        else
          w_head_nxt = r_mem[w_rp_nxt];
      end else if ((r_cnt == '0) && w_enq) begin
        w_head_nxt = w_pcos;
      end
    end

    always_ff @(posedge clk) begin
      if (w_enq)
        r_mem[r_wp] <= w_pcos;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wp   <= '0;
        r_rp   <= '0;
        r_cnt  <= '0;
        r_req  <= 1'b0;
        r_head <= '0;
      end else begin
        if (w_enq)
          r_wp <= r_wp + 1'b1;
        if (w_pop)
          r_rp <= w_rp_nxt;
        r_cnt  <= w_cnt_nxt;
        r_req  <= (w_cnt_nxt != '0);
        r_head <= w_head_nxt;
      end
    end

    assign w_req[gi]                          = r_req;
    assign w_head[gi]                         = r_head;
    assign bus.cos[gi*COS_WIDTH +: COS_WIDTH] = r_head;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_bin   <= '0;
      r_out_cos   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_grant_ok) begin
        r_out_valid <= 1'b1;
        r_out_bin   <= bus.arb_bin;
        r_out_cos   <= w_head[bus.arb_bin];
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if ((|w_ovf) || (w_accept && !w_legal))
        r_err <= 1'b1;
    end
  end

  assign bus.push_ready = w_push_ready;
  assign bus.req        = w_req;
  assign bus.arb_ready  = w_arb_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_bin    = r_out_bin;
  assign bus.out_cos    = r_out_cos;
  assign bus.err        = r_err;
endmodule
`default_nettype wire

// File: tb/tb_ldl_rr_req_agent.sv
`default_nettype none
// ============================================================================
// Module  : tb_ldl_rr_req_agent
// Brief   : Directed self-checking bench for ldl_rr_req_agent.
// Revision: 1.0
// ============================================================================
module tb_ldl_rr_req_agent;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errs;

  ldl_rr_req_agent_if #(.BIN_WIDTH(3), .COS_WIDTH(2)) bus ();

  ldl_rr_req_agent #(.BIN_WIDTH(3), .COS_WIDTH(2), .QDEPTH_LOG2(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.push      = '0;
    bus.push_cos  = '0;
    bus.arb_valid = 1'b0;
    bus.arb_bin   = '0;
    bus.arb_hot   = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic grant(input logic [2:0] bin, input logic [7:0] hot);
    bus.arb_valid = 1'b1;
    bus.arb_bin   = bin;
    bus.arb_hot   = hot;
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_req", 32'(bus.req), 32'h00);
    chk("rst_push_ready", 32'(bus.push_ready), 32'hFF);
    chk("rst_cos", 32'(bus.cos), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_arb_ready", 32'(bus.arb_ready), 32'h1);
    rst_n = 1'b1;
    tick();

    // src0 cos1 and src5 cos3 together, then grant src5
    bus.push = 8'h21; bus.push_cos = 16'h0C01;
    tick();
    idle();
    chk("p05_req", 32'(bus.req), 32'h21);
    chk("p05_cos", 32'(bus.cos), 32'h0C01);
    grant(3'd5, 8'h20);
    tick();
    idle();
    chk("g5_valid", 32'(bus.out_valid), 32'h1);
    chk("g5_bin", 32'(bus.out_bin), 32'h5);
    chk("g5_cos", 32'(bus.out_cos), 32'h3);
    chk("g5_req", 32'(bus.req), 32'h01);
    chk("g5_cosvec", 32'(bus.cos), 32'h0001);
    grant(3'd0, 8'h01);
    tick();
    idle();
    chk("g0_cos", 32'(bus.out_cos), 32'h1);
    chk("g0_req", 32'(bus.req), 32'h00);
    tick();
    chk("drain_valid", 32'(bus.out_valid), 32'h0);

    // src3 fill, overflow, drain in order
    for (int i = 0; i < 4; i++) begin
      bus.push = 8'h08; bus.push_cos = 16'(i << 6);
      tick();
    end
    idle();
    chk("full_push_ready", 32'(bus.push_ready), 32'hF7);
    chk("full_req", 32'(bus.req), 32'h08);
    chk("full_err0", 32'(bus.err), 32'h0);
    bus.push = 8'h08; bus.push_cos = 16'h0040;
    tick();
    idle();
    chk("ovf_err", 32'(bus.err), 32'h1);
    chk("ovf_push_ready", 32'(bus.push_ready), 32'hF7);
    for (int i = 0; i < 4; i++) begin
      grant(3'd3, 8'h08);
      tick();
      chk("fifo_cos", 32'(bus.out_cos), 32'(i));
      chk("fifo_bin", 32'(bus.out_bin), 32'h3);
    end
    idle();
    chk("fifo_req", 32'(bus.req), 32'h00);
    chk("fifo_push_ready", 32'(bus.push_ready), 32'hFF);

    // asynchronous reset with src2 holding three entries
    for (int i = 0; i < 3; i++) begin
      bus.push = 8'h04; bus.push_cos = 16'h0010;
      tick();
    end
    idle();
    chk("pre_rst_req", 32'(bus.req), 32'h04);
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(bus.req), 32'h00);
    chk("arst_push_ready", 32'(bus.push_ready), 32'hFF);
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_err", 32'(bus.err), 32'h0);
    #1;
    rst_n = 1'b1;
    tick();

    // back-pressure then back-to-back reload
    bus.push = 8'hC0; bus.push_cos = 16'h6000;
    tick();
    idle();
    bus.out_ready = 1'b0;
    grant(3'd6, 8'h40);
    tick();
    grant(3'd7, 8'h80);
    chk("bp_arb_ready", 32'(bus.arb_ready), 32'h0);
    tick();
    chk("bp_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_bin", 32'(bus.out_bin), 32'h6);
    chk("bp_cos", 32'(bus.out_cos), 32'h2);
    chk("bp_req", 32'(bus.req), 32'h80);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_arb_ready1", 32'(bus.arb_ready), 32'h1);
    tick();
    idle();
    chk("b2b_valid", 32'(bus.out_valid), 32'h1);
    chk("b2b_bin", 32'(bus.out_bin), 32'h7);
    chk("b2b_cos", 32'(bus.out_cos), 32'h1);
    chk("b2b_req", 32'(bus.req), 32'h00);
    tick();
    chk("b2b_drain", 32'(bus.out_valid), 32'h0);
    chk("b2b_err", 32'(bus.err), 32'h0);

    // illegal grant: empty source
    grant(3'd4, 8'h10);
    tick();
    idle();
    chk("ill_empty_err", 32'(bus.err), 32'h1);
    chk("ill_empty_valid", 32'(bus.out_valid), 32'h0);
    do_reset();

    // illegal grant: two-hot
    bus.push = 8'h03; bus.push_cos = 16'h0009;
    tick();
    idle();
    grant(3'd0, 8'h03);
    tick();
    idle();
    chk("ill_hot_err", 32'(bus.err), 32'h1);
    chk("ill_hot_valid", 32'(bus.out_valid), 32'h0);
    chk("ill_hot_req", 32'(bus.req), 32'h03);
    chk("ill_hot_cos", 32'(bus.cos), 32'h0009);
    do_reset();

    // same-cycle push and pop on src1 holding one entry
    bus.push = 8'h02; bus.push_cos = 16'h0008;
    tick();
    bus.push_cos = 16'h0000;
    grant(3'd1, 8'h02);
    tick();
    idle();
    chk("sp_out_cos", 32'(bus.out_cos), 32'h2);
    chk("sp_out_bin", 32'(bus.out_bin), 32'h1);
    chk("sp_req", 32'(bus.req), 32'h02);
    chk("sp_cos", 32'(bus.cos), 32'h0000);
    chk("sp_err", 32'(bus.err), 32'h0);
    grant(3'd1, 8'h02);
    tick();
    idle();
    chk("sp2_out_cos", 32'(bus.out_cos), 32'h0);
    chk("sp2_req", 32'(bus.req), 32'h00);
    tick();

    // push into full src4 during its pop is refused
    for (int i = 1; i <= 4; i++) begin
      bus.push = 8'h10; bus.push_cos = 16'((i % 4) << 8);
      tick();
    end
    bus.push = 8'h10; bus.push_cos = 16'h0300;
    grant(3'd4, 8'h10);
    tick();
    idle();
    chk("fp_out_cos", 32'(bus.out_cos), 32'h1);
    chk("fp_err", 32'(bus.err), 32'h1);
    chk("fp_push_ready", 32'(bus.push_ready), 32'hFF);
    chk("fp_cos", 32'(bus.cos), 32'h0200);
    for (int i = 2; i <= 4; i++) begin
      grant(3'd4, 8'h10);
      tick();
      chk("fp_drain_cos", 32'(bus.out_cos), 32'(i % 4));
    end
    idle();
    chk("fp_req", 32'(bus.req), 32'h00);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ldl_rr_req_agent.md
Name: ldl_rr_req_agent

Overview:
Requester-side companion to the round-robin priority arbiter. It queues per-source requests, each tagged with a class of service (COS), and presents them to the arbiter as req/cos vectors. It accepts the arbiter's grant (valid/bin/hot under a ready handshake) and pops the granted source's queue. The granted source ID and its COS are then forwarded through a registered output stage to the downstream consumer.

Parameters:
BIN_WIDTH, 3, width of the source index; REQ_WIDTH = 1 << BIN_WIDTH sources.
COS_WIDTH, 2, width of the per-request class of service.
QDEPTH_LOG2, 2, log2 of the per-source queue depth (default 4 entries).

Ports:
clk  input  1  clock, all logic rising-edge.
rst_n  input  1  asynchronous active-low reset.
push  input  REQ_WIDTH  per-source enqueue strobe.
push_cos  input  REQ_WIDTH*COS_WIDTH  per-source COS to enqueue; source i uses bits [i*COS_WIDTH +: COS_WIDTH].
push_ready  output  REQ_WIDTH  per-source "queue not full".
req  output  REQ_WIDTH  to arbiter: source i has a pending entry.
cos  output  REQ_WIDTH*COS_WIDTH  to arbiter: COS of the head entry of each source.
arb_valid  input  1  arbiter grant valid.
arb_bin  input  BIN_WIDTH  granted source index.
arb_hot  input  REQ_WIDTH  granted source, one-hot.
arb_ready  output  1  to arbiter: grant accepted this cycle.
out_valid  output  1  forwarded grant valid.
out_bin  output  BIN_WIDTH  forwarded source index.
out_cos  output  COS_WIDTH  forwarded COS.
out_ready  input  1  downstream accept.
err  output  1  sticky protocol error flag.

Behaviour:
- Reset (rst_n low, asynchronous): all queues empty, req=0, cos=0, push_ready=all 1s, out_valid=0, out_bin=0, out_cos=0, err=0. Reset mid-operation discards all queued entries and any held output.
- Per-source queue i: FIFO of COS values, depth 2^QDEPTH_LOG2, with a count of QDEPTH_LOG2+1 bits.
  - push_ready[i] = (count_i != depth). This is combinational from the registered count.
  - An enqueue occurs when push[i] && push_ready[i].
  - push[i] while full: the entry is dropped, the queue is unchanged, and err is set.
- req and cos are registered state:
  - req[i] = (count_i != 0).
  - cos[i] = head entry of queue i, or 0 when the queue is empty.
  - Push at edge n: req/cos reflect it from cycle n+1.
- arb_ready = !out_valid || out_ready. This is combinational and must not depend on arb_valid.
- Grant accept is (arb_valid && arb_ready) at the edge. On accept:
  - Legal grant: arb_hot is one-hot, arb_hot == (1 << arb_bin), and req[arb_bin] == 1.
    - Pop the head of queue arb_bin.
    - Load out_bin = arb_bin and out_cos = head COS.
    - Set out_valid = 1 from cycle n+1.
  - Illegal grant: no pop, out stage not loaded, err set.
- Output stage:
  - out_valid clears on (out_valid && out_ready) when no new accept occurs in the same cycle.
  - Accept and drain in the same cycle reload the stage back-to-back, giving full throughput.
  - out_bin and out_cos hold stable while out_valid && !out_ready.
- Simultaneous push and pop on the same source in one cycle:
  - The count is unchanged.
  - If the queue was full, push_ready was 0, so the push is refused even though a pop occurs.
  - If the count was 1, the new entry becomes head and req stays 1.
- Pop of the last entry at edge n: req[i]=0 and cos[i]=0 at cycle n+1.
- Pointers wrap modulo depth; the count never exceeds depth and never underflows. An underflow attempt is an illegal grant.
- err is sticky until reset.
- Grant-to-out_valid latency: 1 cycle. Push-to-req latency: 1 cycle.

Test Plan:
- Reset mid-traffic: fill src 2 with 3 entries, then assert rst_n low for one cycle -> req=0, push_ready=8'hFF, out_valid=0, err=0 immediately (asynchronously).
- Push src0 cos=1 and src5 cos=3 in one cycle; grant bin=5/hot=8'h20 with out_ready=1 -> next cycle out_valid=1, out_bin=5, out_cos=3, req=8'h01.
- Fill src3 with 4 entries (cos 0,1,2,3) -> push_ready[3]=0. A 5th push sets err=1. Four grants yield out_cos 0,1,2,3 in order, and req[3]=0 after the last.
- Back-pressure: out_ready=0 with out_valid=1 -> arb_ready=0 and out_bin/out_cos hold. Raise out_ready with arb_valid high -> a new grant loads the same cycle the old one drains.
- Illegal grants: bin=4/hot=8'h10 while req[4]=0 -> err=1, no out_valid. Separately, hot=8'h03 -> err=1, no pop.
- Same-cycle push and grant on src1 (count=1, head cos=2, push cos=0) -> out_cos=2, req[1] stays 1, cos[1]=0.
